ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the decoded operands and control bits produced by the decode stage, holds them in the ID/EX pipeline register, and runs the ALU with operand forwarding. It registers the outcome into the EX/MEM register. It also drives the EX-side forwarding and hazard signals the decode stage uses for early branch compare and load-use stall detection.

## Interface
- No parameters; datapath fixed at 32 bits, 32 registers.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- busA, busB  in  32  decode-stage register read data
- immi  in  16  immediate field
- rs, rt, rd  in  5  register specifiers
- ALUc  in  3  ALU operation (see Operation)
- RegWr, RegDst, extop, ALUSrc, MemWr, MemtoReg  in  1  decode control bits
- ctr_bubble  in  1  load a NOP into ID/EX this edge instead of the decode outputs
- wb_RegWr  in  1, wb_rw  in  5, wb_data  in  32  writeback port (same values sent to the register file)
- EX_result  out  32  combinational ALU result of the instruction in EX
- EX_rw  out  5  destination of the instruction in EX; 0 when it does not write
- EX_rt  out  5  rt of the instruction in EX
- EX_MemtoReg  out  1  instruction in EX is a load
- Mem_MemtoReg  out  1  instruction in MEM is a load
- mem_result  out  32  registered ALU result (memory address or writeback value)
- mem_store  out  32  registered forwarded rt operand (store data)
- mem_rw  out  5; mem_RegWr, mem_MemWr  out  1  registered MEM-stage controls

## Operation
- ID/EX register captures rs, rt, destination, busA, busB, extended immediate and all control bits on every edge.
- Destination = RegDst ? rd : rt.
- Immediate = extop ? sign-extend(immi) : zero-extend(immi).
- ctr_bubble=1: ID/EX loads NOP. All control bits are 0, destination is 0, and data fields are 0.
- Operand forwarding, per operand, applied to the ID/EX register contents:
  - Highest priority is EX/MEM: mem_RegWr && mem_rw!=0 && mem_rw==src selects mem_result.
  - Next is WB: wb_RegWr && wb_rw!=0 && wb_rw==src selects wb_data.
  - Otherwise the latched bus value is used.
  - Register 0 is never forwarded.
- ALU B input = ALUSrc ? immediate : forwarded rt. mem_store always takes the forwarded rt.
- ALUc encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 slt (signed), 110 sltu
  - 111 lui (B<<16)
- Add and sub wrap modulo 2^32 with no overflow trap. slt and sltu return 32'd0 or 32'd1.
- EX_rw is forced to 0 when the EX instruction has RegWr=0, so the decode-stage compare `EX_rw==rs` never matches a non-writing instruction.
- EX/MEM register captures EX_result, mem_store, destination, RegWr, MemWr and MemtoReg on every edge.

## Timing
- Reset: every ID/EX and EX/MEM field is 0. After reset, EX_result=0, EX_rw=0, EX_rt=0, EX_MemtoReg=0, Mem_MemtoReg=0, and all mem_* outputs are 0.
- rst and ctr_bubble together: rst wins, and both registers clear.
- Latency:
  - Instruction in ID during cycle n appears on EX_* in cycle n+1 (combinational from ID/EX).
  - The same instruction appears on mem_* in cycle n+2.
- Forwarding is fully combinational within the cycle; no stall originates here.
- A load followed by a dependent ALU instruction relies on decode asserting ctr_bubble. This block makes no load-use check of its own.
- WB data written in the same cycle as an EX read is taken via the WB forward path, so there is no register-file write-through dependency.

## Structure
- Shared package `pipe_pkg`: ALUc encodings (ALU_ADD … ALU_LUI), NOP control bundle, and register-0 constant. The decode control unit imports the same constants.
- One sub-module: `alu` (a, b, ALUc → result), purely combinational.
- ID/EX and EX/MEM registers and forwarding muxes live in `ex_stage`.

## Test plan
- Reset: hold rst 2 cycles with nonzero inputs → all outputs 0 for those cycles and one cycle after release.
- addi: rs=1, busA=5, immi=16'hFFFF, extop=1, ALUSrc=1, ALUc=000, RegWr=1, RegDst=0, rt=2 → next cycle EX_result=4, EX_rw=2; following cycle mem_result=4, mem_rw=2, mem_RegWr=1.
- Back-to-back forward: `add r3=r1+r2` (busA=7, busB=8), then `sub r4=r3-r1` with stale busA=0, busA'=7 → second EX_result=8 (forwarded 15-7). With both EX/MEM and WB targeting r3 (WB value 99), EX/MEM wins.
- Bubble: load with rt=5 in ID, then ctr_bubble=1 → Mem_MemtoReg=1 in the cycle where EX holds the NOP. The NOP shows EX_rw=0, EX_MemtoReg=0, and mem_RegWr=0 a cycle later.
- Register 0: instruction writing r0 (RegWr=1, dest 0) followed by a reader of r0 with busA=0 → operand stays 0, no forward.
- ALU corners: slt with 0x80000000 vs 1 → 1; sltu → 0; add 0xFFFFFFFF+1 → 0; lui immi=0x1234 → 0x12340000.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes, the execute-stage control
// bundle with its NOP value, and the forwarding match helper.
package pipe_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_LUI  = 3'b111
    } alu_op_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic    reg_wr;
        logic    mem_wr;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e alu_op;
    } ex_ctrl_t;

    localparam ex_ctrl_t NOP_CTRL = '{
        reg_wr:     1'b0,
        mem_wr:     1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        alu_op:     ALU_ADD
    };

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic sign_ext);
        return sign_ext ? {{16{imm[15]}}, imm} : {16'd0, imm};
    endfunction

    // A producer only forwards when it really writes a register other than r0.
    function automatic logic fwd_hit(input logic wr, input logic [4:0] dst, input logic [4:0] src);
        return wr && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU used by the execute stage.
module alu
    import pipe_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  ALUc,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_op_e'(ALUc))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {31'd0, (a < b)};
            ALU_LUI:  result = {b[15:0], 16'd0};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, operand forwarding, ALU and EX/MEM
// register, plus the EX-side hazard outputs consumed by decode.
module ex_stage
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    input  logic [15:0] immi,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [2:0]  ALUc,
    input  logic        RegWr,
    input  logic        RegDst,
    input  logic        extop,
    input  logic        ALUSrc,
    input  logic        MemWr,
    input  logic        MemtoReg,
    input  logic        ctr_bubble,
    input  logic        wb_RegWr,
    input  logic [4:0]  wb_rw,
    input  logic [31:0] wb_data,
    output logic [31:0] EX_result,
    output logic [4:0]  EX_rw,
    output logic [4:0]  EX_rt,
    output logic        EX_MemtoReg,
    output logic        Mem_MemtoReg,
    output logic [31:0] mem_result,
    output logic [31:0] mem_store,
    output logic [4:0]  mem_rw,
    output logic        mem_RegWr,
    output logic        mem_MemWr
);

    logic [4:0]  rs_q, rs_d, rt_q, rt_d, rw_q, rw_d;
    logic [31:0] bus_a_q, bus_a_d, bus_b_q, bus_b_d, imm_q, imm_d;
    ex_ctrl_t    ctrl_q, ctrl_d;

    logic [31:0] mem_result_q, mem_result_d, mem_store_q, mem_store_d;
    logic [4:0]  mem_rw_q, mem_rw_d;
    logic        mem_reg_wr_q, mem_reg_wr_d;
    logic        mem_mem_wr_q, mem_mem_wr_d;
    logic        mem_to_reg_q, mem_to_reg_d;

    logic [31:0] op_a, fwd_rt, alu_b, alu_result;
    logic [4:0]  ex_rw;

    always_comb begin
        rs_d    = rs;
        rt_d    = rt;
        rw_d    = RegDst ? rd : rt;
        bus_a_d = busA;
        bus_b_d = busB;
        imm_d   = extend_imm(immi, extop);
        ctrl_d  = '{reg_wr: RegWr, mem_wr: MemWr, mem_to_reg: MemtoReg,
                    alu_src: ALUSrc, alu_op: alu_op_e'(ALUc)};
        if (ctr_bubble) begin
            rs_d    = REG_ZERO;
            rt_d    = REG_ZERO;
            rw_d    = REG_ZERO;
            bus_a_d = '0;
            bus_b_d = '0;
            imm_d   = '0;
            ctrl_d  = NOP_CTRL;
        end
    end

    // EX/MEM is the younger producer, so it outranks the writeback port.
    always_comb begin
        op_a = bus_a_q;
        if (fwd_hit(mem_reg_wr_q, mem_rw_q, rs_q)) begin
            op_a = mem_result_q;
        end else if (fwd_hit(wb_RegWr, wb_rw, rs_q)) begin
            op_a = wb_data;
        end
        fwd_rt = bus_b_q;
        if (fwd_hit(mem_reg_wr_q, mem_rw_q, rt_q)) begin
            fwd_rt = mem_result_q;
        end else if (fwd_hit(wb_RegWr, wb_rw, rt_q)) begin
            fwd_rt = wb_data;
        end
        alu_b = ctrl_q.alu_src ? imm_q : fwd_rt;
        ex_rw = ctrl_q.reg_wr ? rw_q : REG_ZERO;
    end

    alu u_alu (
        .a      (op_a),
        .b      (alu_b),
        .ALUc   (ctrl_q.alu_op),
        .result (alu_result)
    );

    always_comb begin
        mem_result_d = alu_result;
        mem_store_d  = fwd_rt;
        mem_rw_d     = ex_rw;
        mem_reg_wr_d = ctrl_q.reg_wr;
        mem_mem_wr_d = ctrl_q.mem_wr;
        mem_to_reg_d = ctrl_q.mem_to_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q         <= REG_ZERO;
            rt_q         <= REG_ZERO;
            rw_q         <= REG_ZERO;
            bus_a_q      <= '0;
            bus_b_q      <= '0;
            imm_q        <= '0;
            ctrl_q       <= NOP_CTRL;
            mem_result_q <= '0;
            mem_store_q  <= '0;
            mem_rw_q     <= REG_ZERO;
            mem_reg_wr_q <= 1'b0;
            mem_mem_wr_q <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rw_q         <= rw_d;
            bus_a_q      <= bus_a_d;
            bus_b_q      <= bus_b_d;
            imm_q        <= imm_d;
            ctrl_q       <= ctrl_d;
            mem_result_q <= mem_result_d;
            mem_store_q  <= mem_store_d;
            mem_rw_q     <= mem_rw_d;
            mem_reg_wr_q <= mem_reg_wr_d;
            mem_mem_wr_q <= mem_mem_wr_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign EX_result    = alu_result;
    assign EX_rw        = ex_rw;
    assign EX_rt        = rt_q;
    assign EX_MemtoReg  = ctrl_q.mem_to_reg;
    assign Mem_MemtoReg = mem_to_reg_q;
    assign mem_result   = mem_result_q;
    assign mem_store    = mem_store_q;
    assign mem_rw       = mem_rw_q;
    assign mem_RegWr    = mem_reg_wr_q;
    assign mem_MemWr    = mem_mem_wr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: each issued instruction pushes its expected EX
// and MEM outputs, which are popped and checked as the instruction advances.
module tb_ex_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] busA, busB, wb_data;
    logic [15:0] immi;
    logic [4:0]  rs, rt, rd, wb_rw;
    logic [2:0]  ALUc;
    logic        RegWr, RegDst, extop, ALUSrc, MemWr, MemtoReg, ctr_bubble, wb_RegWr;
    logic [31:0] EX_result, mem_result, mem_store;
    logic [4:0]  EX_rw, EX_rt, mem_rw;
    logic        EX_MemtoReg, Mem_MemtoReg, mem_RegWr, mem_MemWr;

    ex_stage dut (
        .clk(clk), .rst(rst), .busA(busA), .busB(busB), .immi(immi),
        .rs(rs), .rt(rt), .rd(rd), .ALUc(ALUc), .RegWr(RegWr), .RegDst(RegDst),
        .extop(extop), .ALUSrc(ALUSrc), .MemWr(MemWr), .MemtoReg(MemtoReg),
        .ctr_bubble(ctr_bubble), .wb_RegWr(wb_RegWr), .wb_rw(wb_rw), .wb_data(wb_data),
        .EX_result(EX_result), .EX_rw(EX_rw), .EX_rt(EX_rt), .EX_MemtoReg(EX_MemtoReg),
        .Mem_MemtoReg(Mem_MemtoReg), .mem_result(mem_result), .mem_store(mem_store),
        .mem_rw(mem_rw), .mem_RegWr(mem_RegWr), .mem_MemWr(mem_MemWr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [15:0] immi;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [2:0]  aluc;
        logic        reg_wr, reg_dst, extop, alu_src, mem_wr, mem_to_reg, bubble;
    } stim_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rw;
        logic [4:0]  rt;
        logic        mtr;
        logic [31:0] store;
        logic        reg_wr;
        logic        mem_wr;
        logic        wb_wr;
        logic [4:0]  wb_rw;
        logic [31:0] wb_data;
    } exp_t;

    exp_t pend_q[$];
    exp_t ex_item, mem_item;
    bit   ex_valid, mem_valid;
    int   n_checks, n_fail;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    function automatic stim_t mk_r(input logic [2:0] aluc, input logic [4:0] rs_i, input logic [4:0] rt_i,
                                   input logic [4:0] rd_i, input logic [31:0] a, input logic [31:0] b,
                                   input logic reg_wr);
        stim_t s;
        s = '0;
        s.aluc = aluc; s.rs = rs_i; s.rt = rt_i; s.rd = rd_i;
        s.bus_a = a; s.bus_b = b; s.reg_wr = reg_wr; s.reg_dst = 1'b1;
        return s;
    endfunction

    function automatic stim_t mk_i(input logic [2:0] aluc, input logic [4:0] rs_i, input logic [4:0] rt_i,
                                   input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                                   input logic ext, input logic reg_wr, input logic mem_wr, input logic mtr);
        stim_t s;
        s = '0;
        s.aluc = aluc; s.rs = rs_i; s.rt = rt_i; s.rd = 5'd31;
        s.bus_a = a; s.bus_b = b; s.immi = imm; s.extop = ext; s.alu_src = 1'b1;
        s.reg_wr = reg_wr; s.mem_wr = mem_wr; s.mem_to_reg = mtr;
        return s;
    endfunction

    function automatic exp_t mk_e(input logic [31:0] result, input logic [4:0] rw_e, input logic [4:0] rt_e,
                                  input logic mtr, input logic [31:0] store, input logic reg_wr,
                                  input logic mem_wr);
        exp_t e;
        e = '0;
        e.result = result; e.rw = rw_e; e.rt = rt_e; e.mtr = mtr;
        e.store = store; e.reg_wr = reg_wr; e.mem_wr = mem_wr;
        return e;
    endfunction

    function automatic exp_t with_wb(input exp_t e_in, input logic [4:0] rw_w, input logic [31:0] data);
        exp_t e;
        e = e_in;
        e.wb_wr = 1'b1; e.wb_rw = rw_w; e.wb_data = data;
        return e;
    endfunction

    task automatic drive_inputs(input stim_t s);
        busA = s.bus_a; busB = s.bus_b; immi = s.immi;
        rs = s.rs; rt = s.rt; rd = s.rd; ALUc = s.aluc;
        RegWr = s.reg_wr; RegDst = s.reg_dst; extop = s.extop; ALUSrc = s.alu_src;
        MemWr = s.mem_wr; MemtoReg = s.mem_to_reg; ctr_bubble = s.bubble;
    endtask

    task automatic apply_stimulus(input stim_t s, input exp_t e);
        drive_inputs(s);
        pend_q.push_back(e);
    endtask

    task automatic check_output();
        if (ex_valid) begin
            check32("EX_result", EX_result, ex_item.result);
            check32("EX_rw", 32'(EX_rw), 32'(ex_item.rw));
            check32("EX_rt", 32'(EX_rt), 32'(ex_item.rt));
            check32("EX_MemtoReg", 32'(EX_MemtoReg), 32'(ex_item.mtr));
        end
        if (mem_valid) begin
            check32("mem_result", mem_result, mem_item.result);
            check32("mem_store", mem_store, mem_item.store);
            check32("mem_rw", 32'(mem_rw), 32'(mem_item.rw));
            check32("mem_RegWr", 32'(mem_RegWr), 32'(mem_item.reg_wr));
            check32("mem_MemWr", 32'(mem_MemWr), 32'(mem_item.mem_wr));
            check32("Mem_MemtoReg", 32'(Mem_MemtoReg), 32'(mem_item.mtr));
        end
    endtask

    // Advance one edge, shift the scoreboard, present the writeback port
    // that belongs to the instruction now in EX, then compare.
    task automatic cycle();
        @(posedge clk);
        mem_item  = ex_item;
        mem_valid = ex_valid;
        if (pend_q.size() > 0) begin
            ex_item  = pend_q.pop_front();
            ex_valid = 1'b1;
        end else begin
            ex_item  = '0;
            ex_valid = 1'b0;
        end
        #1;
        wb_RegWr = ex_item.wb_wr;
        wb_rw    = ex_item.wb_rw;
        wb_data  = ex_item.wb_data;
        #1;
        check_output();
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_EX_result"}, EX_result, 32'd0);
        check32({tag, "_EX_rw"}, 32'(EX_rw), 32'd0);
        check32({tag, "_EX_rt"}, 32'(EX_rt), 32'd0);
        check32({tag, "_EX_MemtoReg"}, 32'(EX_MemtoReg), 32'd0);
        check32({tag, "_Mem_MemtoReg"}, 32'(Mem_MemtoReg), 32'd0);
        check32({tag, "_mem_result"}, mem_result, 32'd0);
        check32({tag, "_mem_store"}, mem_store, 32'd0);
        check32({tag, "_mem_rw"}, 32'(mem_rw), 32'd0);
        check32({tag, "_mem_RegWr"}, 32'(mem_RegWr), 32'd0);
        check32({tag, "_mem_MemWr"}, 32'(mem_MemWr), 32'd0);
    endtask

    initial begin
        stim_t s;
        exp_t  e;
        n_checks = 0;
        n_fail   = 0;
        ex_valid = 1'b0;
        mem_valid = 1'b0;
        ex_item  = '0;
        mem_item = '0;

        rst = 1'b1;
        s = mk_r(ALU_OR, 5'd3, 5'd4, 5'd5, 32'hAAAA_5555, 32'h1234_5678, 1'b1);
        s.mem_to_reg = 1'b1; s.mem_wr = 1'b1;
        drive_inputs(s);
        wb_RegWr = 1'b1; wb_rw = 5'd3; wb_data = 32'd55;
        @(posedge clk); #2;
        check_all_zero("reset_cyc1");
        @(posedge clk); #2;
        check_all_zero("reset_cyc2");
        rst = 1'b0;
        wb_RegWr = 1'b0; wb_rw = 5'd0; wb_data = 32'd0;
        #1;
        check_all_zero("post_release");

        apply_stimulus(mk_i(ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd123, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0),
                       mk_e(32'd4, 5'd2, 5'd2, 1'b0, 32'd123, 1'b1, 1'b0));
        cycle();
        s = '0; s.bubble = 1'b1;
        apply_stimulus(s, mk_e(32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0));
        cycle();
        apply_stimulus(mk_r(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd7, 32'd8, 1'b1),
                       mk_e(32'd15, 5'd3, 5'd2, 1'b0, 32'd8, 1'b1, 1'b0));
        cycle();
        // r3 comes from EX/MEM even though WB also offers r3=99.
        apply_stimulus(mk_r(ALU_SUB, 5'd3, 5'd1, 5'd4, 32'd0, 32'd7, 1'b1),
                       with_wb(mk_e(32'd8, 5'd4, 5'd1, 1'b0, 32'd7, 1'b1, 1'b0), 5'd3, 32'd99));
        cycle();
        apply_stimulus(mk_r(ALU_OR, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 1'b1),
                       with_wb(mk_e(32'd107, 5'd5, 5'd4, 1'b0, 32'd8, 1'b1, 1'b0), 5'd3, 32'd99));
        cycle();
        apply_stimulus(mk_i(ALU_ADD, 5'd6, 5'd5, 32'd100, 32'd0, 16'd4, 1'b1, 1'b1, 1'b0, 1'b1),
                       mk_e(32'd104, 5'd5, 5'd5, 1'b1, 32'd107, 1'b1, 1'b0));
        cycle();
        s = mk_r(ALU_OR, 5'd9, 5'd5, 5'd7, 32'd77, 32'd66, 1'b1);
        s.bubble = 1'b1; s.mem_to_reg = 1'b1;
        apply_stimulus(s, mk_e(32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0));
        cycle();
        apply_stimulus(mk_r(ALU_ADD, 5'd1, 5'd2, 5'd0, 32'd3, 32'd4, 1'b1),
                       mk_e(32'd7, 5'd0, 5'd2, 1'b0, 32'd4, 1'b1, 1'b0));
        cycle();
        apply_stimulus(mk_r(ALU_OR, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 1'b1),
                       with_wb(mk_e(32'd0, 5'd6, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0), 5'd0, 32'd55));
        cycle();
        apply_stimulus(mk_r(ALU_SLT, 5'd7, 5'd8, 5'd9, 32'h8000_0000, 32'd1, 1'b0),
                       mk_e(32'd1, 5'd0, 5'd8, 1'b0, 32'd1, 1'b0, 1'b0));
        cycle();
        apply_stimulus(mk_r(ALU_SLTU, 5'd7, 5'd8, 5'd9, 32'h8000_0000, 32'd1, 1'b1),
                       mk_e(32'd0, 5'd9, 5'd8, 1'b0, 32'd1, 1'b1, 1'b0));
        cycle();
        apply_stimulus(mk_r(ALU_SLT, 5'd7, 5'd8, 5'd9, 32'd1, 32'h8000_0000, 1'b0),
                       mk_e(32'd0, 5'd0, 5'd8, 1'b0, 32'h8000_0000, 1'b0, 1'b0));
        cycle();
        apply_stimulus(mk_r(ALU_ADD, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFFF, 32'd1, 1'b1),
                       mk_e(32'd0, 5'd12, 5'd11, 1'b0, 32'd1, 1'b1, 1'b0));
        cycle();
        apply_stimulus(mk_i(ALU_LUI, 5'd0, 5'd13, 32'd0, 32'd5, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0),
                       mk_e(32'h1234_0000, 5'd13, 5'd13, 1'b0, 32'd5, 1'b1, 1'b0));
        cycle();
        apply_stimulus(mk_r(ALU_AND, 5'd14, 5'd15, 5'd16, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1),
                       mk_e(32'hF000_F000, 5'd16, 5'd15, 1'b0, 32'hFF00_FF00, 1'b1, 1'b0));
        cycle();
        apply_stimulus(mk_r(ALU_XOR, 5'd14, 5'd15, 5'd17, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1),
                       mk_e(32'h0FF0_0FF0, 5'd17, 5'd15, 1'b0, 32'hFF00_FF00, 1'b1, 1'b0));
        cycle();
        apply_stimulus(mk_i(ALU_OR, 5'd18, 5'd19, 32'd0, 32'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0),
                       mk_e(32'h0000_FFFF, 5'd19, 5'd19, 1'b0, 32'd0, 1'b1, 1'b0));
        cycle();
        // Store: address uses the immediate while store data takes the WB forward.
        apply_stimulus(mk_i(ALU_ADD, 5'd20, 5'd21, 32'd200, 32'h0000_DEAD, 16'd8, 1'b1, 1'b0, 1'b1, 1'b0),
                       with_wb(mk_e(32'd208, 5'd0, 5'd21, 1'b0, 32'h0000_BEEF, 1'b0, 1'b1), 5'd21, 32'h0000_BEEF));
        cycle();
        s = '0; s.bubble = 1'b1;
        apply_stimulus(s, mk_e(32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0));
        cycle();
        apply_stimulus(mk_r(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 1'b1),
                       mk_e(32'd3, 5'd3, 5'd2, 1'b0, 32'd2, 1'b1, 1'b0));
        cycle();

        // Reset together with a bubble must still clear both registers.
        s = mk_r(ALU_SUB, 5'd4, 5'd5, 5'd6, 32'd50, 32'd9, 1'b1);
        s.bubble = 1'b1;
        drive_inputs(s);
        rst = 1'b1;
        @(posedge clk); #2;
        check_all_zero("rst_and_bubble");
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
